// File: rtl/lm_fe_pkg.sv
// Shared constants and controller state encoding for the lm_fe median filter.
package lm_fe_pkg;

    localparam int unsigned IMG_W    = 128;
    localparam int unsigned WIN      = 7;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned MED_RANK = WIN * WIN / 2;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StSlide,
        StDone
    } lm_state_e;

endpackage

// File: rtl/lm_fe_median.sv
// Sorted window of N pixels: removes one value and inserts another each enabled cycle.
module lm_fe_median
    import lm_fe_pkg::*;
#(
    parameter int unsigned N    = WIN * WIN,
    parameter int unsigned RANK = MED_RANK
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [PIX_W-1:0] rm_i,
    input  logic [PIX_W-1:0] ins_i,
    output logic [PIX_W-1:0] med_o
);

    logic [PIX_W-1:0] win_q [N];
    logic [PIX_W-1:0] win_d [N];
    logic [PIX_W-1:0] shr   [N];
    logic             found;
    int               rm_idx;
    int               ins_idx;

    always_comb begin
        found  = 1'b0;
        rm_idx = int'(N) - 1;
        for (int i = 0; i < int'(N); i++) begin
            if (!found && win_q[i] == rm_i) begin
                found  = 1'b1;
                rm_idx = i;
            end
        end
        // Close the gap left by the removed entry; last slot is a don't-care.
        for (int i = 0; i < int'(N) - 1; i++) begin
            shr[i] = (i < rm_idx) ? win_q[i] : win_q[i+1];
        end
        shr[N-1] = '0;
        ins_idx = 0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            if (shr[i] < ins_i) ins_idx = ins_idx + 1;
        end
        win_d[0] = (ins_idx == 0) ? ins_i : shr[0];
        for (int i = 1; i < int'(N); i++) begin
            if (i < ins_idx)       win_d[i] = shr[i];
            else if (i == ins_idx) win_d[i] = ins_i;
            else                   win_d[i] = shr[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(N); i++) win_q[i] <= '0;
        end else if (en_i) begin
            win_q <= win_d;
        end
    end

    assign med_o = win_q[RANK];

endmodule

// File: rtl/lm_fe.sv
// Streaming WIN x WIN zero-padded median filter over one square image per reset.
module lm_fe #(
    parameter int unsigned IMG_W = lm_fe_pkg::IMG_W,
    parameter int unsigned WIN   = lm_fe_pkg::WIN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Din,
    input  logic       in_en,
    output logic       busy,
    output logic       out_valid,
    output logic [7:0] Dout
);
    import lm_fe_pkg::*;

    localparam int unsigned HALF    = WIN / 2;
    localparam int unsigned LB_AW   = $clog2(WIN);
    localparam int unsigned LB_ROWS = 1 << LB_AW;
    localparam int unsigned COL_W   = $clog2(IMG_W);
    localparam int unsigned ROW_W   = $clog2(IMG_W + 1);
    localparam int unsigned S_LAST  = IMG_W + WIN - 1;
    localparam int unsigned S_W     = $clog2(S_LAST + 1);
    localparam int unsigned K_W     = $clog2(WIN);

    lm_state_e        state_q, state_d;
    logic [ROW_W-1:0] wr_row_q, wr_row_d;
    logic [COL_W-1:0] wr_col_q, wr_col_d;
    logic [COL_W-1:0] out_row_q, out_row_d;
    logic [S_W-1:0]   s_q, s_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             pend_q, pend_d;
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] dout_q, dout_d;

    logic [PIX_W-1:0] lbuf_q [LB_ROWS][IMG_W];
    logic             accept;
    logic             win_en;
    logic [PIX_W-1:0] ins_pix, rm_pix, med;
    int               rd_row, rm_col, need_rows, need_next;

    // Slide step s inserts column s and removes column s-WIN, so the window
    // starts and ends each row all-zero and never needs an explicit clear.
    always_comb begin
        rd_row  = int'(out_row_q) + int'(k_q) - int'(HALF);
        rm_col  = int'(s_q) - int'(WIN);
        ins_pix = '0;
        rm_pix  = '0;
        if (rd_row >= 0 && rd_row < int'(IMG_W)) begin
            if (int'(s_q) < int'(IMG_W)) ins_pix = lbuf_q[rd_row[LB_AW-1:0]][s_q[COL_W-1:0]];
            if (rm_col >= 0)             rm_pix  = lbuf_q[rd_row[LB_AW-1:0]][rm_col[COL_W-1:0]];
        end
    end

    always_comb begin
        busy        = (state_q == StSlide) || (state_q == StDone);
        accept      = in_en && !busy;
        state_d     = state_q;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        out_row_d   = out_row_q;
        s_d         = s_q;
        k_d         = k_q;
        pend_d      = 1'b0;
        win_en      = 1'b0;
        out_valid_d = pend_q;
        dout_d      = pend_q ? med : dout_q;
        need_rows   = int'(out_row_q) + int'(HALF) + 1;
        if (need_rows > int'(IMG_W)) need_rows = int'(IMG_W);
        need_next   = int'(out_row_q) + int'(HALF) + 2;
        if (need_next > int'(IMG_W)) need_next = int'(IMG_W);

        unique case (state_q)
            StIdle, StFill: begin
                if (accept) begin
                    state_d = StFill;
                    if (wr_col_q == COL_W'(IMG_W - 1)) begin
                        wr_col_d = '0;
                        wr_row_d = wr_row_q + 1'b1;
                        if (int'(wr_row_q) + 1 >= need_rows) state_d = StSlide;
                    end else begin
                        wr_col_d = wr_col_q + 1'b1;
                    end
                end
            end
            StSlide: begin
                win_en = 1'b1;
                if (k_q == K_W'(WIN - 1)) begin
                    k_d    = '0;
                    pend_d = (s_q >= S_W'(HALF)) && (s_q < S_W'(IMG_W + HALF));
                    if (s_q == S_W'(S_LAST)) begin
                        s_d = '0;
                        if (out_row_q == COL_W'(IMG_W - 1)) begin
                            state_d = StDone;
                        end else begin
                            out_row_d = out_row_q + 1'b1;
                            if (int'(wr_row_q) < need_next) state_d = StFill;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            out_row_q   <= '0;
            s_q         <= '0;
            k_q         <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            out_row_q   <= out_row_d;
            s_q         <= s_d;
            k_q         <= k_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    // Line buffer is deliberately not reset; every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (accept) lbuf_q[wr_row_q[LB_AW-1:0]][wr_col_q] <= Din;
    end

    lm_fe_median #(
        .N   (WIN * WIN),
        .RANK(WIN * WIN / 2)
    ) u_median (
        .clk_i (clk),
        .rst_ni(reset),
        .en_i  (win_en),
        .rm_i  (rm_pix),
        .ins_i (ins_pix),
        .med_o (med)
    );

    assign out_valid = out_valid_q;
    assign Dout      = dout_q;

endmodule

// File: tb/tb_lm_fe.sv
// Directed bench for lm_fe on a reduced 16x16 image with a 7x7 window.
module tb_lm_fe;

    localparam int IMG_W  = 16;
    localparam int WIN    = 7;
    localparam int HALF   = WIN / 2;
    localparam int NPIX   = IMG_W * IMG_W;
    localparam int LOGSZ  = 8 * NPIX;
    localparam int LIMIT  = 20000;
    localparam int BUDGET = 9375;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       in_en = 1'b0;
    logic [7:0] Din   = 8'h00;
    logic       busy;
    logic       out_valid;
    logic [7:0] Dout;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] got [LOGSZ];
    int         out_cnt  = 0;

    lm_fe #(
        .IMG_W(IMG_W),
        .WIN  (WIN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Din      (Din),
        .in_en    (in_en),
        .busy     (busy),
        .out_valid(out_valid),
        .Dout     (Dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (out_cnt < LOGSZ) got[out_cnt] <= Dout;
            out_cnt <= out_cnt + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0d outputs", out_cnt);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return (r == 8 && c == 8) ? 8'hC8 : 8'h00;
            3:       return 8'((r + c) % 256);
            default: return 8'((r * 37 + c * 11 + r * c * 5) % 256);
        endcase
    endfunction

    function automatic logic [7:0] ref_med(input int mode, input int r, input int c);
        logic [7:0] v [WIN*WIN];
        logic [7:0] t;
        int         n;
        int         j;
        n = 0;
        for (int dr = -HALF; dr <= HALF; dr++) begin
            for (int dc = -HALF; dc <= HALF; dc++) begin
                if (r + dr >= 0 && r + dr < IMG_W && c + dc >= 0 && c + dc < IMG_W)
                    v[n] = pix(mode, r + dr, c + dc);
                else
                    v[n] = 8'h00;
                n++;
            end
        end
        for (int i = 1; i < WIN * WIN; i++) begin
            t = v[i];
            j = i - 1;
            while (j >= 0 && v[j] > t) begin
                v[j+1] = v[j];
                j--;
            end
            v[j+1] = t;
        end
        return v[(WIN * WIN) / 2];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_en = 1'b0;
        Din   = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // Offers the whole image obeying busy, then waits for all outputs plus a tail.
    task automatic run_image(input int mode, input bit hold_z, output int base,
                             output int cycles);
        int idx;
        int guard;
        base  = out_cnt;
        idx   = 0;
        guard = 0;
        while (idx < NPIX && guard < LIMIT) begin
            in_en = 1'b1;
            Din   = pix(mode, idx / IMG_W, idx % IMG_W);
            if (busy === 1'b0) idx++;
            @(negedge clk);
            guard++;
        end
        in_en = hold_z;
        Din   = hold_z ? 8'hzz : 8'h00;
        while ((out_cnt - base) < NPIX && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        cycles = guard;
        repeat (40) @(negedge clk);
        in_en = 1'b0;
        Din   = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (Dout !== 8'h00) begin
            n_fail++; $display("FAIL reset_dout: got %h want 00", Dout);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_flat(input int mode, input string name);
        int base;
        int cyc;
        do_reset();
        run_image(mode, 1'b0, base, cyc);
        n_checks++;
        if (out_cnt - base !== NPIX) begin
            n_fail++; $display("FAIL %s_count: got %0d want %0d", name, out_cnt - base, NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            n_checks++;
            if (got[base+i] !== 8'h00) begin
                n_fail++;
                $display("FAIL %s_pix(%0d,%0d): got %h want 00", name, i / IMG_W, i % IMG_W,
                         got[base+i]);
            end
        end
    endtask

    task automatic test_ff_image();
        int         base;
        int         cyc;
        int         pr [9] = '{0, 0, 0, 0, 1, 1, 0, 8, 15};
        int         pc [9] = '{0, 1, 2, 3, 0, 1, 8, 8, 15};
        logic [7:0] pe [9] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        do_reset();
        run_image(1, 1'b0, base, cyc);
        n_checks++;
        if (out_cnt - base !== NPIX) begin
            n_fail++; $display("FAIL ff_count: got %0d want %0d", out_cnt - base, NPIX);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (got[base + pr[i] * IMG_W + pc[i]] !== pe[i]) begin
                n_fail++;
                $display("FAIL ff_pix(%0d,%0d): got %h want %h", pr[i], pc[i],
                         got[base + pr[i] * IMG_W + pc[i]], pe[i]);
            end
        end
    endtask

    task automatic test_ramp();
        int base;
        int cyc;
        do_reset();
        run_image(3, 1'b1, base, cyc);
        n_checks++;
        if (out_cnt - base !== NPIX) begin
            n_fail++; $display("FAIL ramp_count: got %0d want %0d", out_cnt - base, NPIX);
        end
        n_checks++;
        if (cyc > BUDGET) begin
            n_fail++; $display("FAIL ramp_latency: took %0d cycles, limit %0d", cyc, BUDGET);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL ramp_busy_done: got %b want 1", busy);
        end
        for (int i = 0; i < NPIX; i++) begin
            n_checks++;
            if (got[base+i] !== ref_med(3, i / IMG_W, i % IMG_W)) begin
                n_fail++;
                $display("FAIL ramp_pix(%0d,%0d): got %h want %h", i / IMG_W, i % IMG_W,
                         got[base+i], ref_med(3, i / IMG_W, i % IMG_W));
            end
        end
    endtask

    task automatic test_reset_mid();
        int idx;
        int guard;
        int base;
        int cyc;
        do_reset();
        idx   = 0;
        guard = 0;
        while (idx < 6 * IMG_W && guard < LIMIT) begin
            in_en = 1'b1;
            Din   = pix(3, idx / IMG_W, idx % IMG_W);
            if (busy === 1'b0) idx++;
            @(negedge clk);
            guard++;
        end
        in_en = 1'b0;
        guard = 0;
        while (out_valid !== 1'b1 && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_wait_valid: got %b want 1", out_valid);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_async_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (Dout !== 8'h00) begin
            n_fail++; $display("FAIL mid_async_dout: got %h want 00", Dout);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_async_busy: got %b want 0", busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_image(4, 1'b0, base, cyc);
        n_checks++;
        if (out_cnt - base !== NPIX) begin
            n_fail++; $display("FAIL mid_count: got %0d want %0d", out_cnt - base, NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            n_checks++;
            if (got[base+i] !== ref_med(4, i / IMG_W, i % IMG_W)) begin
                n_fail++;
                $display("FAIL mid_pix(%0d,%0d): got %h want %h", i / IMG_W, i % IMG_W,
                         got[base+i], ref_med(4, i / IMG_W, i % IMG_W));
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat(0, "zero");
        test_ff_image();
        test_flat(2, "spike");
        test_ramp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
